// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache that fills whole lines in word order.
// Define ICACHE_STATS_EN to add the saturating hit_cnt/miss_cnt outputs.
module instr_cache #(
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic              inv,
  output logic [DATA_W-1:0] instr,
  output logic              instr_vld,
  output logic              stall,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = LINES << OFFSET_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]   miss_idx_q, miss_idx_d;
  logic [OFFSET_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]    instr_q, instr_d;
  logic                 vld_q, vld_d;

  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [DATA_W-1:0]    data_q [WORDS];

  logic [TAG_W-1:0]     a_tag;
  logic [INDEX_W-1:0]   a_idx;
  logic [OFFSET_W-1:0]  a_off;
  logic                 hit, lookup, fill_wr, fill_last;

  assign a_tag = addr[ADDR_W-1 -: TAG_W];
  assign a_idx = addr[OFFSET_W +: INDEX_W];
  assign a_off = addr[OFFSET_W-1:0];

  // inv in the lookup cycle forces a miss
  assign hit       = valid_q[a_idx] && (tag_q[a_idx] == a_tag) && !inv;
  assign lookup    = (state_q == S_IDLE) && re;
  assign fill_wr   = (state_q == S_FILL) && mem_rdy && !inv;
  assign fill_last = fill_wr && (cnt_q == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (re && !hit) state_d = S_FILL;
      S_FILL: begin
        if (inv)            state_d = S_IDLE;
        else if (fill_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall    = (state_q != S_IDLE) || (re && !hit);
    mem_re   = (state_q == S_FILL);
    mem_addr = {miss_tag_q, miss_idx_q, cnt_q};
  end

  always_comb begin
    valid_d    = inv ? '0 : valid_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    vld_d      = 1'b0;
    if (lookup && hit) begin
      instr_d = data_q[{a_idx, a_off}];
      vld_d   = 1'b1;
    end
    // a line being refilled is never valid until its last word lands
    if (lookup && !hit) begin
      miss_tag_d     = a_tag;
      miss_idx_d     = a_idx;
      cnt_d          = '0;
      valid_d[a_idx] = 1'b0;
    end
    if (fill_wr)   cnt_d = cnt_q + 1'b1;
    if (fill_last) valid_d[miss_idx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      cnt_q      <= '0;
      instr_q    <= '0;
      vld_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      vld_q      <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_wr)   data_q[{miss_idx_q, cnt_q}] <= mem_rdata;
    if (fill_last) tag_q[miss_idx_q] <= miss_tag_q;
  end

  assign instr     = instr_q;
  assign instr_vld = vld_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup && hit && (hit_cnt_q != '1))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (lookup && !hit && (miss_cnt_q != '1))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Bench for instr_cache: directed scenarios then random fetches vs a line model.
// Backing memory is a fixed address hash with random per-word latency.
module tb_instr_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re = 1'b0;
  logic        inv = 1'b0;
  logic        mem_rdy = 1'b0;
  logic [21:0] addr = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr;
  logic        instr_vld, stall, mem_re;
  logic [21:0] mem_addr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int vecs = 0;
  int errs = 0;
  bit          mvalid [64];
  logic [13:0] mtag   [64];
  int unsigned m_hits = 0;
  int unsigned m_miss = 0;

  always #5 clk = ~clk;

  instr_cache dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .re        (re),
    .addr      (addr),
    .inv       (inv),
    .instr     (instr),
    .instr_vld (instr_vld),
    .stall     (stall),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  function automatic logic [31:0] memfn(input logic [21:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5EED_0F0F;
  endfunction

  function automatic bit mhit(input logic [21:0] a);
    return mvalid[a[7:2]] && (mtag[a[7:2]] == a[21:8]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  task automatic chk_stats();
`ifdef ICACHE_STATS_EN
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_miss);
`endif
  endtask

  task automatic give_word(input logic [21:0] wa);
    chk("fill_mem_re", 32'(mem_re), 32'd1);
    chk("fill_addr", 32'(mem_addr), 32'(wa));
    mem_rdy = 1'b1;
    mem_rdata = memfn(wa);
    tick();
    mem_rdy = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic fetch(input logic [21:0] a, input bit with_inv);
    logic [21:0] base;
    bit h;
    int lat;
    if (with_inv) clear_model();
    h = mhit(a);
    re = 1'b1;
    addr = a;
    inv = with_inv;
    #1;
    chk("lookup_stall", 32'(stall), 32'(!h));
    if (!h) begin
      m_miss++;
      base = {a[21:2], 2'b00};
      tick();
      inv = 1'b0;
      for (int w = 0; w < 4; w++) begin
        lat = $urandom_range(0, 2);
        for (int k = 0; k < lat; k++) begin
          re = 1'($urandom);
          addr = 22'($urandom);
          chk("wait_stall", 32'(stall), 32'd1);
          chk("wait_addr", 32'(mem_addr), 32'(base) + 32'(w));
          tick();
        end
        give_word(base + 22'(w));
      end
      re = 1'b1;
      addr = a;
      chk("done_stall", 32'(stall), 32'd1);
      chk("done_mem_re", 32'(mem_re), 32'd0);
      tick();
      mvalid[a[7:2]] = 1'b1;
      mtag[a[7:2]] = a[21:8];
      chk("retry_stall", 32'(stall), 32'd0);
    end
    m_hits++;
    tick();
    inv = 1'b0;
    chk("instr_vld", 32'(instr_vld), 32'd1);
    chk("instr", instr, memfn(a));
    chk_stats();
  endtask

  task automatic idle_cycle();
    re = 1'b0;
    tick();
    chk("idle_vld", 32'(instr_vld), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
  endtask

  task automatic inv_pulse();
    re = 1'b0;
    inv = 1'b1;
    tick();
    inv = 1'b0;
    clear_model();
    chk("inv_stall", 32'(stall), 32'd0);
    chk_stats();
  endtask

  // start a miss on a, deliver nwords, then abandon via inv
  task automatic abort_fill(input logic [21:0] a, input int nwords,
                            input bit inv_on_last);
    re = 1'b1;
    addr = a;
    #1;
    chk("abort_stall", 32'(stall), 32'd1);
    m_miss++;
    tick();
    re = 1'b0;
    for (int w = 0; w < nwords; w++) give_word({a[21:2], 2'(w)});
    if (inv_on_last) begin
      mem_rdy = 1'b1;
      mem_rdata = memfn({a[21:2], 2'd3});
    end
    inv = 1'b1;
    tick();
    inv = 1'b0;
    mem_rdy = 1'b0;
    clear_model();
    chk("abort_mem_re", 32'(mem_re), 32'd0);
    chk("abort_idle_stall", 32'(stall), 32'd0);
    mem_rdy = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rdy = 1'b0;
    chk("stray_rdy_mem_re", 32'(mem_re), 32'd0);
    chk_stats();
  endtask

  initial begin
    logic [21:0] ra;
    int r;
    clear_model();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_instr", instr, 32'd0);
    chk("rst_vld", 32'(instr_vld), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk_stats();
    rst_n = 1'b1;
    tick();

    fetch(22'h0, 1'b0);
    fetch(22'h1, 1'b0);
    fetch(22'h2, 1'b0);
    fetch(22'h3, 1'b0);
`ifdef ICACHE_STATS_EN
    chk("t6_hits", hit_cnt, 32'd4);
    chk("t6_miss", miss_cnt, 32'd1);
`endif
    inv_pulse();
    fetch(22'h0, 1'b0);

    fetch(22'h100, 1'b0);
    fetch(22'h0, 1'b0);
    fetch(22'h102, 1'b0);

    abort_fill(22'h0, 2, 1'b0);
    fetch(22'h0, 1'b0);
    abort_fill(22'h44, 3, 1'b1);
    fetch(22'h45, 1'b0);
    fetch(22'h45, 1'b1);

    re = 1'b1;
    addr = 22'h3_0008;
    tick();
    give_word(22'h3_0008);
    rst_n = 1'b0;
    re = 1'b0;
    tick();
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_vld", 32'(instr_vld), 32'd0);
    chk("midrst_mem_re", 32'(mem_re), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_instr", instr, 32'd0);
    rst_n = 1'b1;
    clear_model();
    m_hits = 0;
    m_miss = 0;
    chk_stats();
    fetch(22'h3_0009, 1'b0);
    fetch(22'h45, 1'b0);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 24);
      ra = 22'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) |
                $urandom_range(0, 3));
      if (r == 0)      idle_cycle();
      else if (r == 1) inv_pulse();
      else if (r == 2) fetch(ra, 1'b1);
      else             fetch(ra, 1'b0);
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
